// File: rtl/feature_packer_if.sv
// Handshake bundle between the serial feature source, the packer and the frame consumer.
interface feature_packer_if #(
    parameter int FLOAT = 32,
    parameter int NFEAT = 42,
    parameter int CNT_W = 16
);
    logic [FLOAT-1:0]       in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [NFEAT*FLOAT-1:0] feature;
    logic                   frame_valid;
    logic                   frame_ready;
    logic                   err_len;
    logic                   err_clr;
    logic [CNT_W-1:0]       frame_cnt;

    modport master (
        output in_data, in_valid, in_last, frame_ready, err_clr,
        input  in_ready, feature, frame_valid, err_len, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_last, frame_ready, err_clr,
        output in_ready, feature, frame_valid, err_len, frame_cnt
    );
endinterface

// File: rtl/feature_packer.sv
// Packs a serial stream of feature words into NFEAT-word frames using two
// ping-pong buffers, so one frame can be filled while the other is consumed.
module feature_packer #(
    parameter int FLOAT = 32,
    parameter int NFEAT = 42,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    feature_packer_if.slave   bus
);
    localparam int WIDX_W = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NFEAT - 1);

    logic [1:0]        full_q, full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic              err_len_q, err_len_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FLOAT-1:0]  mem_q [2][NFEAT];

    logic accept;
    logic consume;
    logic at_last;
    logic len_err;

    assign bus.in_ready    = !full_q[wr_sel_q];
    assign bus.frame_valid = full_q[rd_sel_q];
    assign bus.err_len     = err_len_q;
    assign bus.frame_cnt   = frame_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NFEAT; gi++) begin : g_feature
            assign bus.feature[gi*FLOAT +: FLOAT] = mem_q[rd_sel_q][gi];
        end
    endgenerate

    always_comb begin
        accept  = bus.in_valid && !full_q[wr_sel_q];
        consume = full_q[rd_sel_q] && bus.frame_ready;
        at_last = (widx_q == LAST_IDX);
        len_err = accept && (at_last != bus.in_last);

        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        widx_d      = widx_q;
        frame_cnt_d = frame_cnt_q;
        err_len_d   = err_len_q;

        // A consume and a completion never target the same buffer: completion
        // needs full[wr_sel]=0 while consume needs full[rd_sel]=1.
        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            frame_cnt_d      = frame_cnt_q + 1'b1;
        end

        if (accept) begin
            if (at_last) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
                widx_d           = '0;
            end else if (bus.in_last) begin
                widx_d = '0;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end

        if (bus.err_clr) begin
            err_len_d = 1'b0;
        end else if (len_err) begin
            err_len_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            widx_q      <= '0;
            err_len_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            widx_q      <= widx_d;
            err_len_q   <= err_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage is never reset; contents only matter once the buffer's full flag is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_sel_q][widx_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_feature_packer.sv
// Randomized bench for feature_packer, checked against a frame-level queue model.
module tb_feature_packer;
    localparam int FLOAT = 32;
    localparam int NFEAT = 42;
    localparam int CNT_W = 4;

    typedef logic [FLOAT-1:0] frame_t [NFEAT];

    logic clk;
    logic rst_n;

    feature_packer_if #(.FLOAT(FLOAT), .NFEAT(NFEAT), .CNT_W(CNT_W)) bus ();

    feature_packer #(.FLOAT(FLOAT), .NFEAT(NFEAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: completed frames waiting for the consumer, and the partial frame.
    frame_t           held[$];
    logic [FLOAT-1:0] cur[$];
    bit               m_err;
    int               m_cnt;
    bit               chk_en;

    int n_checks;
    int n_errs;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: compare outputs with the model, then apply one clock.
    task automatic cycle(input bit v, input logic [FLOAT-1:0] d, input bit l,
                         input bit fr, input bit clr, input bit rst, output bit acc);
        bit cons;
        bit ev;
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_last     = l;
        bus.frame_ready = fr;
        bus.err_clr     = clr;
        rst_n           = !rst;
        #1;
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(held.size() < 2));
            check("frame_valid", 32'(bus.frame_valid), 32'(held.size() > 0));
            check("err_len", 32'(bus.err_len), 32'(m_err));
            check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
            if (held.size() > 0) begin
                for (int k = 0; k < NFEAT; k++)
                    check($sformatf("feature[%0d]", k), bus.feature[k*FLOAT +: FLOAT], held[0][k]);
            end
        end
        acc = 1'b0;
        ev  = 1'b0;
        if (rst) begin
            held.delete();
            cur.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            acc  = v && (held.size() < 2);
            cons = (held.size() > 0) && fr;
            if (cons) begin
                void'(held.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (acc) begin
                cur.push_back(d);
                if (cur.size() == NFEAT) begin
                    frame_t f;
                    for (int k = 0; k < NFEAT; k++) f[k] = cur[k];
                    held.push_back(f);
                    cur.delete();
                    if (!l) ev = 1'b1;
                end else if (l) begin
                    cur.delete();
                    ev = 1'b1;
                end
            end
            if (clr) m_err = 1'b0;
            else if (ev) m_err = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit fr, input bit clr, input bit rst);
        bit acc;
        cycle(1'b0, $urandom, 1'($urandom), fr, clr, rst, acc);
    endtask

    // Pushes n accepted words; last_at<0 means in_last is never raised.
    // ready_mode: 0 = frame_ready low, 1 = high, 2 = random.
    task automatic run_words(input int n, input int last_at, input bit rand_valid,
                             input int ready_mode, input bit idx_data, input int base,
                             input bit rand_clr, output int stalls);
        int  i;
        int  guard;
        bit  v, l, fr, clr, acc;
        logic [FLOAT-1:0] d;
        i = 0;
        guard = 0;
        stalls = 0;
        while (i < n) begin
            v   = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            d   = idx_data ? FLOAT'(base + i + 1) : FLOAT'($urandom);
            l   = v ? (i == last_at) : 1'($urandom);
            fr  = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom);
            clr = rand_clr && ($urandom_range(0, 19) == 0);
            cycle(v, d, l, fr, clr, 1'b0, acc);
            if (acc) i++;
            else stalls++;
            guard++;
            if (guard > 5000) begin
                check("timeout", 32'(i), 32'(n));
                break;
            end
        end
        $display("frame: words=%0d last_at=%0d stalls=%0d cnt=%0d err=%0d",
                 n, last_at, stalls, m_cnt, m_err);
    endtask

    initial begin
        int st;
        int bubbles;
        int kind;
        int len;
        bit acc;
        n_checks = 0;
        n_errs   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.frame_ready = 1'b0; bus.err_clr = 1'b0;
        @(negedge clk);
        idle(1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;

        // Reset values and basic frame
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_err", 32'(bus.err_len), 32'd0);
        check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b1, 0, 1'b0, st);
        check("basic_valid", 32'(bus.frame_valid), 32'd1);
        check("basic_w0", bus.feature[0 +: FLOAT], 32'd1);
        check("basic_w41", bus.feature[(NFEAT-1)*FLOAT +: FLOAT], 32'd42);
        check("basic_cnt", 32'(bus.frame_cnt), 32'd0);
        check("basic_err", 32'(bus.err_len), 32'd0);

        // Backpressure: two frames fill both buffers, third is blocked
        idle(1'b0, 1'b0, 1'b1);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b1, 100, 1'b0, st);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b1, 200, 1'b0, st);
        check("bp_ready_low", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'hdead, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("bp_hold_w0", bus.feature[0 +: FLOAT], 32'd101);
        idle(1'b1, 1'b0, 1'b0);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        check("bp_next_w0", bus.feature[0 +: FLOAT], 32'd201);
        check("bp_cnt", 32'(bus.frame_cnt), 32'd1);
        run_words(NFEAT, NFEAT - 1, 1'b1, 2, 1'b1, 300, 1'b0, st);

        // Short frame then an intact frame
        idle(1'b0, 1'b0, 1'b1);
        run_words(10, 9, 1'b0, 0, 1'b0, 0, 1'b0, st);
        check("short_err", 32'(bus.err_len), 32'd1);
        check("short_no_valid", 32'(bus.frame_valid), 32'd0);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b1, 0, 1'b0, st);
        check("short_next_w0", bus.feature[0 +: FLOAT], 32'd1);
        check("short_next_w41", bus.feature[(NFEAT-1)*FLOAT +: FLOAT], 32'd42);

        // Missing last, then err_clr
        idle(1'b0, 1'b0, 1'b1);
        run_words(NFEAT, -1, 1'b0, 0, 1'b0, 0, 1'b0, st);
        check("nolast_valid", 32'(bus.frame_valid), 32'd1);
        check("nolast_err", 32'(bus.err_len), 32'd1);
        idle(1'b0, 1'b1, 1'b0);
        check("clr_err", 32'(bus.err_len), 32'd0);

        // err_clr wins over a simultaneous length error
        cycle(1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        check("clr_priority", 32'(bus.err_len), 32'd0);

        // Reset in the middle of a frame with a frame already held
        idle(1'b0, 1'b0, 1'b1);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b0, 0, 1'b0, st);
        run_words(21, -1, 1'b0, 0, 1'b0, 0, 1'b0, st);
        idle(1'b0, 1'b0, 1'b1);
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_valid", 32'(bus.frame_valid), 32'd0);
        check("midrst_cnt", 32'(bus.frame_cnt), 32'd0);
        run_words(NFEAT, NFEAT - 1, 1'b0, 0, 1'b1, 0, 1'b0, st);
        check("midrst_w0", bus.feature[0 +: FLOAT], 32'd1);
        check("midrst_w41", bus.feature[(NFEAT-1)*FLOAT +: FLOAT], 32'd42);

        // Counter wrap with full-rate streaming
        idle(1'b0, 1'b0, 1'b1);
        bubbles = 0;
        for (int f = 0; f < 17; f++) begin
            run_words(NFEAT, NFEAT - 1, 1'b0, 1, 1'b0, 0, 1'b0, st);
            bubbles += st;
        end
        check("wrap_bubbles", 32'(bubbles), 32'd0);
        idle(1'b1, 1'b0, 1'b0);
        check("wrap_cnt", 32'(bus.frame_cnt), 32'd1);
        check("wrap_drained", 32'(bus.frame_valid), 32'd0);

        // Random mix of frame kinds, gaps, backpressure and clears
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                len = $urandom_range(1, NFEAT - 1);
                run_words(len, len - 1, 1'b1, 2, 1'b0, 0, 1'b1, st);
            end else if (kind == 1) begin
                run_words(NFEAT, -1, 1'b1, 2, 1'b0, 0, 1'b1, st);
            end else begin
                run_words(NFEAT, NFEAT - 1, 1'b1, 2, 1'b0, 0, 1'b1, st);
            end
        end
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
